// File: rtl/timepulse_pkg.sv
// Shared types and defaults for the time-pulse generator.
//
// Contents:
//   DefNumTp / DefDiv / DefCntW : default values for NUM_TP, DIV and CNT_W
//   tp_state_e                  : sequencer FSM state
//
// Build option: TIMEPULSE_STEP_EN adds the StStep state (single-step operation).
package timepulse_pkg;

  localparam int unsigned DefNumTp = 12;
  localparam int unsigned DefDiv   = 1;
  localparam int unsigned DefCntW  = 16;

`ifdef TIMEPULSE_STEP_EN
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep
  } tp_state_e;
`else
  typedef enum logic [0:0] {
    StIdle,
    StRun
  } tp_state_e;
`endif

endpackage

// File: rtl/timepulse_prescaler.sv
// Pulse-width prescaler: a DIV-clock down-counter that emits a one-clock advance tick.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (counter cleared to 0)
//   load : restart a fresh pulse (counter set to DIV-1); wins over en
//   en   : count while the sequencer is free-running
//   tick : high on the last clock of the current pulse while en is high
module timepulse_prescaler
  import timepulse_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Reload = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = Reload;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = Reload;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timepulse_generator.sv
// Memory-cycle time-pulse generator: walks a registered one-hot pulse train
// tp[0..NUM_TP-1], each pulse DIV clocks wide, and counts completed cycles.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, overrides everything
//   run        : level request to generate cycles (sampled at cycle start/end)
//   step_mode  : select single-step operation
//   step       : one-clock strobe advancing one pulse in single-step operation
//   tp         : one-hot time pulses (registered)
//   tp_idx     : index of the active pulse, 0 when idle
//   busy       : any tp bit high
//   cyc_end    : strobe on the final clock of tp[NUM_TP-1]
//   cyc_count  : completed-cycle counter, wraps modulo 2^CNT_W
//
// Build option: TIMEPULSE_STEP_EN compiles in the single-step state; without it
// step_mode and step are accepted but have no effect.
module timepulse_generator
  import timepulse_pkg::*;
#(
  parameter int unsigned NUM_TP = DefNumTp,
  parameter int unsigned DIV    = DefDiv,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      step_mode,
  input  logic                      step,
  output logic [NUM_TP-1:0]         tp,
  output logic [$clog2(NUM_TP)-1:0] tp_idx,
  output logic                      busy,
  output logic                      cyc_end,
  output logic [CNT_W-1:0]          cyc_count
);

  localparam int unsigned IdxW = $clog2(NUM_TP);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_TP - 1);

  tp_state_e         state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_TP-1:0] tp_q, tp_d;
  logic [CNT_W-1:0]  cyc_count_q, cyc_count_d;

  logic pre_load;
  logic pre_tick;
  logic adv;

  timepulse_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .load (pre_load),
    .en   (state_q == StRun),
    .tick (pre_tick)
  );

`ifndef TIMEPULSE_STEP_EN
  logic unused_step;
  assign unused_step = step ^ step_mode;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pre_load = 1'b0;
    adv      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          idx_d    = '0;
          pre_load = 1'b1;
          state_d  = StRun;
`ifdef TIMEPULSE_STEP_EN
          if (step_mode) state_d = StStep;
`endif
        end
      end
      StRun: begin
        if (pre_tick) begin
          adv = 1'b1;
`ifdef TIMEPULSE_STEP_EN
          // Step mode is only taken at a pulse boundary.
          if (step_mode) state_d = StStep;
`endif
        end
      end
`ifdef TIMEPULSE_STEP_EN
      StStep: begin
        if (!step_mode) begin
          // Resume with a full-width pulse on the currently held index.
          state_d  = StRun;
          pre_load = 1'b1;
        end else if (step) begin
          adv = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Advancing off the last pulse ends the cycle; run decides wrap versus idle.
    if (adv) begin
      if (idx_q == LastIdx) begin
        idx_d = '0;
        if (!run) state_d = StIdle;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    cyc_end     = adv && (idx_q == LastIdx);
    cyc_count_d = cyc_count_q + CNT_W'(cyc_end);
    tp_d        = (state_d == StIdle) ? '0 : (NUM_TP'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tp_q        <= '0;
      cyc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tp_q        <= tp_d;
      cyc_count_q <= cyc_count_d;
    end
  end

  assign tp        = tp_q;
  assign tp_idx    = idx_q;
  assign busy      = |tp_q;
  assign cyc_count = cyc_count_q;

endmodule

// File: doc/timepulse_generator.md
TIMEPULSE_GENERATOR -- requirements
Module: timepulse_generator

Interface
REQ-001 Parameter NUM_TP, default 12, SHALL set the number of time pulses per memory cycle (legal range 2..32).
REQ-002 Parameter DIV, default 1, SHALL set clocks per pulse (legal range 1..256).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the completed-cycle counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 run  input  1  SHALL be the level request to generate cycles.
REQ-007 step_mode  input  1  SHALL select single-step operation.
REQ-008 step  input  1  SHALL be a one-clock strobe advancing one pulse in step mode.
REQ-009 tp  output  NUM_TP  SHALL be the one-hot time pulses, registered.
REQ-010 tp_idx  output  $clog2(NUM_TP)  SHALL be the index of the active pulse; 0 when idle.
REQ-011 busy  output  1  SHALL be high whenever any tp bit is high.
REQ-012 cyc_end  output  1  SHALL be a one-clock strobe on the final clock of tp[NUM_TP-1].
REQ-013 cyc_count  output  CNT_W  SHALL count completed cycles.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and STEP.
REQ-015 IDLE: tp=0; on run=1, enter RUN with tp[0] high from the next clock.
REQ-016 RUN: each pulse SHALL last exactly DIV clocks, then advance to the next index.
REQ-017 After tp[NUM_TP-1] the index SHALL wrap to 0 with no gap clock if run=1, else enter IDLE with tp=0.
REQ-018 Deassertion of run mid-cycle SHALL NOT truncate the cycle; the current cycle completes.
REQ-019 Exactly one tp bit SHALL be high while busy; no clock SHALL have two bits high.
REQ-020 cyc_end SHALL assert and cyc_count SHALL increment (modulo 2^CNT_W) on the same clock for every completed cycle.
REQ-021 STEP: the active pulse SHALL be held indefinitely; each step strobe advances exactly one index, ignoring DIV.
REQ-022 RUN with step_mode=1 SHALL enter STEP at the next pulse boundary; STEP with step_mode=0 SHALL resume RUN with a fresh DIV count.
REQ-023 In STEP, a step at index NUM_TP-1 SHALL produce cyc_end and wrap to 0 if run=1, else enter IDLE.
REQ-024 step while not in STEP SHALL be ignored.
REQ-025 IDLE with run=1 and step_mode=1 SHALL enter STEP with tp[0] high.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, tp=0, tp_idx=0, busy=0, cyc_end=0, cyc_count=0, prescaler=0.
REQ-027 rst SHALL override run, step and step_mode and SHALL abort a cycle in progress, including on the same edge as cyc_end.

Configuration
REQ-028 Macro TIMEPULSE_STEP_EN SHALL compile in the STEP state and the step_mode/step logic.
REQ-029 Without TIMEPULSE_STEP_EN, the ports SHALL remain present but be ignored, and the FSM SHALL have only IDLE and RUN.

Structure
REQ-030 Package timepulse_pkg SHALL hold the FSM state typedef and the default constants for NUM_TP, DIV and CNT_W.
REQ-031 Sub-module timepulse_prescaler SHALL implement the DIV down-counter and generate the pulse-advance tick.

Verification
REQ-032 NUM_TP=12, DIV=1, run held high for 30 clocks -> tp[0..11] sequence one clock each; cyc_end on clocks 12 and 24; cyc_count=2.
REQ-033 DIV=3, run high for one cycle then low -> each pulse is 3 clocks wide; cyc_end at clock 36; then IDLE with tp=0.
REQ-034 run drops during tp[4] -> the sequence continues through tp[11], then busy=0; cyc_count increments by 1.
REQ-035 TIMEPULSE_STEP_EN, step_mode=1, 5 step strobes spaced 7 clocks apart -> tp advances 0 to 5, holding between strobes; no cyc_end.
REQ-036 CNT_W=2, 5 full cycles -> cyc_count sequence 1,2,3,0,1.
REQ-037 rst pulsed during tp[7] -> all outputs are zero on the next clock; with run still high, restart at tp[0] one clock after rst drops.
